tx_pkt_dispatcher: RTL
======================

Name: tx_pkt_dispatcher

Overview:
Transmit-direction counterpart of the inband RX packet builder and buffer. Reads fixed 256-word inband packets from the show-ahead TX USB FIFO (rxclk side). Parses the 4-word header and steers the payload to one of NUM_CHAN per-channel sample FIFOs or to the command path (channel 0x1F), which feeds the command interpreter. Extracts per-packet timestamp and burst flags, and counts dropped or malformed packets.

Parameters:
NUM_CHAN, 2, number of sample channels (1..4)
PKT_WORDS, 256, fixed packet length in 16-bit words (header plus payload plus pad)
CTRL_CHAN, 5'h1F, channel number routed to the command path

Ports:
rxclk  input  1  clock
reset  input  1  synchronous active-high reset
have_pkt  input  1  USB FIFO holds ≥PKT_WORDS words
pkt_empty  input  1  USB FIFO empty
pkt_data  input  16  show-ahead FIFO head word
pkt_rdreq  output  1  pop head word
chan_full  input  NUM_CHAN  per-channel FIFO full
chan_wrreq  output  NUM_CHAN  one-hot write strobe
chan_wrdata  output  16  sample word
cmd_WR_enabled  input  1  command sink ready
cmd_WR  output  1  command word strobe
cmd_databus  output  16  command word
cmd_WR_done  output  1  one-cycle pulse after the last command word
pkt_timestamp  output  32  timestamp of the current packet
pkt_chan  output  5  channel field of the current packet
pkt_sob  output  1  start-of-burst flag of the current packet
pkt_eob  output  1  end-of-burst flag of the current packet
hdr_valid  output  1  one-cycle pulse when the header fields are valid
len_err  output  1  sticky: payload length > 504 bytes seen
drop_count  output  16  count of packets discarded (bad channel)
clear_status  input  1  clears len_err and drop_count

Behaviour:
- Reset: state IDLE. All strobes (pkt_rdreq, chan_wrreq, cmd_WR, cmd_WR_done, hdr_valid) are 0. pkt_timestamp, pkt_chan, pkt_sob, pkt_eob, len_err and drop_count are 0. Reset mid-packet abandons the packet; the USB FIFO is flushed externally by the same reset.
- Packet format, in word order:
  - w0 = {tag[3:0], rsvd[2:0], len[8:0]}, where len is the payload length in bytes.
  - w1 = {overrun, underrun, sob, eob, rsvd[6:0], chan[4:0]}.
  - w2 = timestamp[15:0].
  - w3 = timestamp[31:16].
  - w4..w255 are the payload followed by pad words.
- Payload words: nwords = (len+1)>>1.
  - If len > 504, clamp nwords to 252 and set len_err.
- FSM states: IDLE, HDR0, HDR1, TS0, TS1, PAYLOAD, PAD, DONE.
  - IDLE → HDR0 when have_pkt & ~pkt_empty.
  - HDR0, HDR1, TS0 and TS1 each pop one word in one cycle (pkt_rdreq=1) and latch the corresponding field.
  - hdr_valid pulses in the cycle after TS1 pops, with all header outputs stable.
  - TS1 → PAYLOAD if nwords > 0, else → PAD.
  - PAYLOAD: pop plus write one word per cycle while the sink is ready and ~pkt_empty; stall otherwise (pkt_rdreq=0, no write). Decrement the word counter on each transfer. → PAD when the counter reaches 0.
  - PAD: pop and discard (no write) until 256 words total have been consumed, then → DONE.
  - DONE: one cycle, then IDLE. DONE pulses cmd_WR_done if pkt_chan == CTRL_CHAN and nwords > 0.
- Routing:
  - Sample channel (chan < NUM_CHAN):
    - Sink ready = ~chan_full[chan].
    - chan_wrreq[chan] = pkt_rdreq in PAYLOAD.
    - chan_wrdata = pkt_data (combinational pass-through, same cycle as the pop).
  - Control channel (chan == CTRL_CHAN):
    - Sink ready = cmd_WR_enabled.
    - cmd_WR = pkt_rdreq in PAYLOAD; cmd_databus = pkt_data.
  - Any other chan: payload is popped and discarded at full rate (treated like PAD). drop_count increments once per such packet, saturating at 16'hFFFF.
- Word accounting: a 9-bit consumed counter.
  - pkt_rdreq is never asserted when pkt_empty=1.
  - Exactly PKT_WORDS pops per packet, always, including clamped and dropped packets.
- Simultaneous events:
  - clear_status and an increment in the same cycle: clear wins.
  - clear_status and a len_err set in the same cycle: the set wins.
- Latency: the first payload write occurs 4 cycles after the IDLE exit, absent stalls. Throughput is 1 word/cycle.

Test Plan:
- Chan 0 packet: len=504, 252 ramp words, timestamp 0x12345678, sob=1 → 252 writes on chan_wrreq[0] with matching data; hdr_valid once with pkt_timestamp=0x12345678 and pkt_sob=1; 256 pops in total.
- Chan 1 packet, len=7: → 4 writes on chan_wrreq[1], then 248 pad pops with no writes; cmd_WR_done stays 0.
- Control packet (chan 0x1F, len=20), cmd_WR_enabled low for 10 cycles mid-payload → cmd_WR paused exactly during the low window; 10 words in total; cmd_WR_done pulses once in DONE.
- chan_full[0] asserted for 5 cycles at payload word 100 → no pop and no write during the stall; data order preserved; total pops still 256.
- Bad channel 3 (NUM_CHAN=2) twice, then clear_status → drop_count goes 1, 2, then 0; no chan_wrreq or cmd_WR activity.
- len=510, then reset asserted at payload word 50 of the next packet → len_err=1 and 252 writes for the first packet; after reset, FSM is IDLE, len_err=0 and all strobes are 0.

Source files
------------

// File: rtl/tx_pkt_dispatcher.sv
// tx_pkt_dispatcher: pops fixed-length inband packets from the show-ahead TX USB
// FIFO, parses the 4-word header and steers the payload to one sample
// channel FIFO or to the command path. Tracks timestamp/burst flags, a
// sticky over-length error and a count of packets dropped for a bad channel.
module tx_pkt_dispatcher #(
    parameter int         NUM_CHAN  = 2,
    parameter int         PKT_WORDS = 256,
    parameter logic [4:0] CTRL_CHAN = 5'h1F
) (
    input  logic                rxclk,
    input  logic                reset,
    input  logic                have_pkt,
    input  logic                pkt_empty,
    input  logic [15:0]         pkt_data,
    output logic                pkt_rdreq,
    input  logic [NUM_CHAN-1:0] chan_full,
    output logic [NUM_CHAN-1:0] chan_wrreq,
    output logic [15:0]         chan_wrdata,
    input  logic                cmd_WR_enabled,
    output logic                cmd_WR,
    output logic [15:0]         cmd_databus,
    output logic                cmd_WR_done,
    output logic [31:0]         pkt_timestamp,
    output logic [4:0]          pkt_chan,
    output logic                pkt_sob,
    output logic                pkt_eob,
    output logic                hdr_valid,
    output logic                len_err,
    output logic [15:0]         drop_count,
    input  logic                clear_status
);
    // Header is 4 words; the rest of the packet is payload plus pad.
    localparam logic [8:0] PKT_LEN   = 9'(PKT_WORDS);
    localparam logic [8:0] MAX_WORDS = 9'(PKT_WORDS - 4);
    localparam logic [8:0] MAX_BYTES = 9'(2 * (PKT_WORDS - 4));

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, TS0, TS1, PAYLOAD, PAD, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  consumed_q, consumed_d;
    logic [8:0]  nwords_q, nwords_d;
    logic [8:0]  words_left_q, words_left_d;
    logic [4:0]  chan_q, chan_d;
    logic [31:0] ts_q, ts_d;
    logic        sob_q, sob_d, eob_q, eob_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        cmd_done_q, cmd_done_d;
    logic        len_err_q, len_err_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic [NUM_CHAN-1:0] chan_sel;
    logic                is_ctrl, chan_ok, sink_ready, pop, payload_pop;
    logic [9:0]          len_p1;

    // One decode line per sample channel; chan_q is compared, never used as an index.
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        assign chan_sel[gi]   = (chan_q == 5'(gi));
        assign chan_wrreq[gi] = payload_pop & chan_sel[gi];
    end

    assign is_ctrl     = (chan_q == CTRL_CHAN);
    assign chan_ok     = (|chan_sel) | is_ctrl;
    assign sink_ready  = is_ctrl ? cmd_WR_enabled : |(chan_sel & ~chan_full);
    assign payload_pop = pop & (state_q == PAYLOAD);
    assign len_p1      = {1'b0, pkt_data[8:0]} + 10'd1;

    // Pop decision: combinational so a stall or an empty FIFO blocks the pop the same cycle.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            HDR0, HDR1, TS0, TS1: pop = ~pkt_empty;
            PAYLOAD:              pop = ~pkt_empty & sink_ready;
            PAD:                  pop = ~pkt_empty & (consumed_q != PKT_LEN);
            default:              pop = 1'b0;
        endcase
    end

    // Next-state and field-capture logic for the packet walk.
    always_comb begin
        state_d      = state_q;
        consumed_d   = (state_q == IDLE) ? 9'd0 : consumed_q + {8'd0, pop};
        nwords_d     = nwords_q;
        words_left_d = words_left_q;
        chan_d       = chan_q;
        ts_d         = ts_q;
        sob_d        = sob_q;
        eob_d        = eob_q;
        hdr_valid_d  = 1'b0;
        cmd_done_d   = 1'b0;
        len_err_d    = len_err_q & ~clear_status;
        drop_count_d = drop_count_q;
        case (state_q)
            IDLE: if (have_pkt && !pkt_empty) state_d = HDR0;
            HDR0: if (pop) begin
                if (pkt_data[8:0] > MAX_BYTES) begin
                    nwords_d  = MAX_WORDS;
                    len_err_d = 1'b1;   // a set in the same cycle as clear wins
                end else begin
                    nwords_d  = len_p1[9:1];
                end
                words_left_d = nwords_d;
                state_d      = HDR1;
            end
            HDR1: if (pop) begin
                chan_d  = pkt_data[4:0];
                sob_d   = pkt_data[13];
                eob_d   = pkt_data[12];
                state_d = TS0;
            end
            TS0: if (pop) begin
                ts_d[15:0] = pkt_data;
                state_d    = TS1;
            end
            TS1: if (pop) begin
                ts_d[31:16] = pkt_data;
                hdr_valid_d = 1'b1;
                if (!chan_ok) begin
                    // Unknown channel: the payload is discarded at pad rate.
                    if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
                    state_d = PAD;
                end else if (nwords_q != 9'd0) begin
                    state_d = PAYLOAD;
                end else begin
                    state_d = PAD;
                end
            end
            PAYLOAD: if (pop) begin
                words_left_d = words_left_q - 9'd1;
                if (words_left_q == 9'd1) state_d = PAD;
            end
            PAD: if (consumed_q == PKT_LEN) begin
                cmd_done_d = is_ctrl & (nwords_q != 9'd0);
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_status) drop_count_d = 16'd0;
    end

    // State and registered outputs.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q      <= IDLE;
            consumed_q   <= 9'd0;
            nwords_q     <= 9'd0;
            words_left_q <= 9'd0;
            chan_q       <= 5'd0;
            ts_q         <= 32'd0;
            sob_q        <= 1'b0;
            eob_q        <= 1'b0;
            hdr_valid_q  <= 1'b0;
            cmd_done_q   <= 1'b0;
            len_err_q    <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            consumed_q   <= consumed_d;
            nwords_q     <= nwords_d;
            words_left_q <= words_left_d;
            chan_q       <= chan_d;
            ts_q         <= ts_d;
            sob_q        <= sob_d;
            eob_q        <= eob_d;
            hdr_valid_q  <= hdr_valid_d;
            cmd_done_q   <= cmd_done_d;
            len_err_q    <= len_err_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pkt_rdreq     = pop;
    assign chan_wrdata   = pkt_data;
    assign cmd_WR        = payload_pop & is_ctrl;
    assign cmd_databus   = pkt_data;
    assign cmd_WR_done   = cmd_done_q;
    assign pkt_timestamp = ts_q;
    assign pkt_chan      = chan_q;
    assign pkt_sob       = sob_q;
    assign pkt_eob       = eob_q;
    assign hdr_valid     = hdr_valid_q;
    assign len_err       = len_err_q;
    assign drop_count    = drop_count_q;
endmodule
